// File: rtl/pdm_tx_modulator_pkg.sv
// Shared definitions for the PDM transmit path: bit-rate helpers, offset-binary mask and
// the encoding of where a PCM slot gets its sample from.
package pdm_pkg;

  localparam int unsigned PDM_MAX_W = 32'd32;

  typedef enum logic [1:0] {
    SLOT_SRC_NONE   = 2'd0,
    SLOT_SRC_BUF    = 2'd1,
    SLOT_SRC_BYPASS = 2'd2
  } slot_src_e;

  // Divide ratio from clk to bit rate; never below 2 so the bit clock has both phases.
  function automatic int unsigned clk_divide(input int unsigned in_f, input int unsigned out_f);
    int unsigned div;
    if (out_f == 32'd0) begin
      div = 32'd2;
    end else begin
      div = in_f / out_f;
    end
    if (div < 32'd2) begin
      div = 32'd2;
    end
    return div;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // XOR with this mask turns a two's complement sample into offset binary.
  function automatic logic [PDM_MAX_W-1:0] sign_flip_mask(input int unsigned w);
    return {{(PDM_MAX_W-1){1'b0}}, 1'b1} << (w - 32'd1);
  endfunction

endpackage

// File: rtl/pdm_tx_modulator_bit_tick_gen.sv
// Bit-rate divider producing the PDM bit clock and a per-bit update strobe from clk.
// Also used by the microphone capture path so both directions share one bit timing.
module pdm_bit_tick_gen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIVIDE = 32'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  output logic bit_update_o,
  output logic pdm_clk_o,
  output logic bit_tick_o
);

  localparam int unsigned      CNT_W    = cnt_width(CLK_DIVIDE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVIDE - 32'd1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIVIDE / 32'd2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_s;
  logic             pdm_clk_q;
  logic             bit_tick_q;

  // Next divider count and end-of-bit-period strobe.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_s = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      wrap_s = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // pdm_clk follows the next count so its falling edge lands on the data update edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      pdm_clk_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pdm_clk_q  <= (cnt_d >= CNT_HALF);
      bit_tick_q <= wrap_s;
    end
  end

  assign bit_update_o = wrap_s;
  assign pdm_clk_o    = pdm_clk_q;
  assign bit_tick_o   = bit_tick_q;

endmodule

// File: rtl/pdm_tx_modulator.sv
// PCM-to-PDM transmitter: one-entry skid buffer, per-slot sample selection and a
// first-order sigma-delta accumulator whose carry is the PDM bit.
module pdm_tx_modulator
  import pdm_pkg::*;
#(
  parameter int unsigned INPUT_FREQ  = 32'd100_000_000,
  parameter int unsigned OUTPUT_FREQ = 32'd2_400_000,
  parameter int unsigned PCM_W       = 32'd16,
  parameter int unsigned OSR         = 32'd50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PCM_W-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             pdm_clk,
  output logic             pdm_out,
  output logic             bit_tick,
  output logic             underrun
);

  localparam int unsigned      CLK_DIVIDE = clk_divide(INPUT_FREQ, OUTPUT_FREQ);
  localparam int unsigned      BIT_W      = cnt_width(OSR);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(OSR - 32'd1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(32'd1);
  localparam logic [PCM_W-1:0] SIGN_FLIP  = PCM_W'(sign_flip_mask(PCM_W));

  logic [PCM_W-1:0] buf_q;
  logic [PCM_W-1:0] buf_d;
  logic             buf_full_q;
  logic             buf_full_d;
  logic [PCM_W-1:0] cur_q;
  logic [PCM_W-1:0] cur_d;
  logic [PCM_W-1:0] acc_q;
  logic [PCM_W-1:0] acc_d;
  logic [BIT_W-1:0] bitcnt_q;
  logic [BIT_W-1:0] bitcnt_d;
  logic             pdm_out_q;
  logic             pdm_out_d;
  logic             underrun_q;
  logic             underrun_d;

  logic             bit_update_s;
  logic             hs_s;
  logic             load_s;
  slot_src_e        src_s;
  logic [PCM_W-1:0] slot_val_s;
  logic [PCM_W-1:0] cur_sel_s;
  logic [PCM_W-1:0] u_s;
  logic [PCM_W:0]   sum_s;

  pdm_bit_tick_gen #(
    .CLK_DIVIDE(CLK_DIVIDE)
  ) u_tick_gen (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .bit_update_o(bit_update_s),
    .pdm_clk_o   (pdm_clk),
    .bit_tick_o  (bit_tick)
  );

  assign s_tready = ~buf_full_q & ~rst;
  assign hs_s     = s_tvalid & s_tready;
  assign load_s   = bit_update_s & (bitcnt_q == '0);

  // A buffered sample wins; otherwise a sample arriving on the load edge is used directly.
  always_comb begin
    src_s      = SLOT_SRC_NONE;
    slot_val_s = '0;
    if (buf_full_q) begin
      src_s = SLOT_SRC_BUF;
    end else if (hs_s) begin
      src_s = SLOT_SRC_BYPASS;
    end else begin
      src_s = SLOT_SRC_NONE;
    end
    case (src_s)
      SLOT_SRC_BUF:    slot_val_s = buf_q;
      SLOT_SRC_BYPASS: slot_val_s = s_tdata;
      SLOT_SRC_NONE:   slot_val_s = '0;
      default:         slot_val_s = '0;
    endcase
  end

  // Sigma-delta step: the newly loaded sample already drives the first bit of its slot.
  always_comb begin
    cur_sel_s = cur_q;
    if (load_s) begin
      cur_sel_s = slot_val_s;
    end else begin
      cur_sel_s = cur_q;
    end
    u_s   = cur_sel_s ^ SIGN_FLIP;
    sum_s = {1'b0, acc_q} + {1'b0, u_s};
  end

  // Modulator state: cleared while disabled, advanced once per bit period.
  always_comb begin
    cur_d      = cur_q;
    acc_d      = acc_q;
    bitcnt_d   = bitcnt_q;
    pdm_out_d  = pdm_out_q;
    underrun_d = 1'b0;
    if (!enable) begin
      cur_d     = '0;
      acc_d     = '0;
      bitcnt_d  = '0;
      pdm_out_d = 1'b0;
    end else if (bit_update_s) begin
      cur_d      = cur_sel_s;
      acc_d      = sum_s[PCM_W-1:0];
      pdm_out_d  = sum_s[PCM_W];
      underrun_d = load_s & (src_s == SLOT_SRC_NONE);
      if (bitcnt_q == BIT_LAST) begin
        bitcnt_d = '0;
      end else begin
        bitcnt_d = bitcnt_q + BIT_ONE;
      end
    end else begin
      cur_d     = cur_q;
      acc_d     = acc_q;
      bitcnt_d  = bitcnt_q;
      pdm_out_d = pdm_out_q;
    end
  end

  // Skid buffer; it keeps its contents across enable=0 and only a reset discards it.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (load_s && (src_s == SLOT_SRC_BUF)) begin
      buf_full_d = 1'b0;
    end else if (hs_s && !(load_s && (src_s == SLOT_SRC_BYPASS))) begin
      buf_full_d = 1'b1;
      buf_d      = s_tdata;
    end else begin
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cur_q      <= '0;
      acc_q      <= '0;
      bitcnt_q   <= '0;
      pdm_out_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      bitcnt_q   <= bitcnt_d;
      pdm_out_q  <= pdm_out_d;
      underrun_q <= underrun_d;
    end
  end

  assign pdm_out  = pdm_out_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_pdm_tx_modulator.sv
// Bench for pdm_tx_modulator with CLK_DIVIDE=8, OSR=4, PCM_W=16: per-slot bit tables plus a
// sample scoreboard that predicts every bit, underrun pulse and handshake.
`timescale 1ns/1ps
module tb_pdm_tx_modulator;

  localparam int CD  = 8;
  localparam int OSR = 4;

  typedef struct {
    string       nm;
    logic [15:0] smp;
    logic [3:0]  bits;  // bits[i] = pdm_out on bit i of the slot, starting from a cleared acc
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] s_tdata = 16'h0000;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        pdm_clk;
  logic        pdm_out;
  logic        bit_tick;
  logic        underrun;

  pdm_tx_modulator #(
    .INPUT_FREQ (8),
    .OUTPUT_FREQ(1),
    .PCM_W      (16),
    .OSR        (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .pdm_clk (pdm_clk),
    .pdm_out (pdm_out),
    .bit_tick(bit_tick),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard state: accepted samples awaiting a slot, plus the reference accumulator.
  logic [15:0] sb_q[$];
  logic [15:0] m_acc = 16'h0000;
  logic [15:0] m_cur = 16'h0000;
  logic [16:0] m_sum;
  logic        m_out = 1'b0;
  logic        m_exp_ur;
  int          m_bitcnt = 0;
  int          since = 0;
  bit          since_ok = 1'b0;
  int          en_run = 0;
  bit          en_prev = 1'b0;
  bit          rst_prev = 1'b1;
  int          n_under = 0;

  // Monitor: outputs seen at the falling edge reflect the rising edge just passed.
  always @(negedge clk) begin
    if (rst_prev) begin
      sb_q.delete();
      m_acc = 16'h0000; m_cur = 16'h0000; m_out = 1'b0; m_bitcnt = 0;
      since_ok = 1'b0; en_run = 0;
      chk("rst_pdm_out", 32'(pdm_out), 32'd0);
      chk("rst_pdm_clk", 32'(pdm_clk), 32'd0);
      chk("rst_bit_tick", 32'(bit_tick), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
    end else if (!en_prev) begin
      m_acc = 16'h0000; m_cur = 16'h0000; m_out = 1'b0; m_bitcnt = 0;
      since_ok = 1'b0; en_run = 0;
      chk("dis_pdm_out", 32'(pdm_out), 32'd0);
      chk("dis_pdm_clk", 32'(pdm_clk), 32'd0);
      chk("dis_bit_tick", 32'(bit_tick), 32'd0);
      chk("dis_underrun", 32'(underrun), 32'd0);
    end else begin
      en_run++;
      if (bit_tick === 1'b1) begin
        if (since_ok) chk("tick_period", 32'(since + 1), 32'(CD));
        else          chk("first_tick_delay", 32'(en_run), 32'(CD));
        since = 0; since_ok = 1'b1;
        m_exp_ur = 1'b0;
        if (m_bitcnt == 0) begin
          if (sb_q.size() > 0) m_cur = sb_q.pop_front();
          else begin m_cur = 16'h0000; m_exp_ur = 1'b1; end
        end
        m_sum    = {1'b0, m_acc} + {1'b0, m_cur ^ 16'h8000};
        m_acc    = m_sum[15:0];
        m_out    = m_sum[16];
        m_bitcnt = (m_bitcnt + 1) % OSR;
        chk("pdm_out", 32'(pdm_out), 32'(m_out));
        chk("underrun", 32'(underrun), 32'(m_exp_ur));
        chk("pdm_clk_fall", 32'(pdm_clk), 32'd0);
        if (underrun === 1'b1) n_under++;
      end else begin
        chk("pdm_out_hold", 32'(pdm_out), 32'(m_out));
        chk("underrun_idle", 32'(underrun), 32'd0);
        if (since_ok) begin
          since++;
          chk("pdm_clk_phase", 32'(pdm_clk), 32'(since >= CD / 2));
        end
      end
    end
    chk("s_tready", 32'(s_tready), 32'(!rst && sb_q.size() == 0));
    if (s_tvalid && s_tready) sb_q.push_back(s_tdata);
    en_prev  = enable;
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and drop valid right after the edge that accepts it.
  task automatic send(input logic [15:0] d);
    int t;
    t = 0;
    step();
    s_tdata  = d;
    s_tvalid = 1'b1;
    while (s_tready !== 1'b1 && t < 200) begin
      step();
      t++;
    end
    chk("send_ready_timeout", 32'(s_tready), 32'd1);
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_ticks(input int n, output logic [3:0] bits);
    int got;
    int t;
    got = 0; t = 0; bits = 4'b0000;
    while (got < n && t < n * CD * 4) begin
      @(negedge clk);
      t++;
      if (bit_tick === 1'b1) begin
        if (got < 4) bits[got] = pdm_out;
        got++;
      end
    end
    chk("tick_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish after %0d ns", 2000000);
    $fatal(1, "watchdog expired");
  end

  vec_t        vecs[7];
  logic [3:0]  bits;
  int          u0;
  int          t;

  initial begin
    vecs[0] = '{"zero_mid",    16'h0000, 4'b1010};
    vecs[1] = '{"neg_full",    16'h8000, 4'b0000};
    vecs[2] = '{"pos_full",    16'h7FFF, 4'b1110};
    vecs[3] = '{"pos_half",    16'h4000, 4'b1110};
    vecs[4] = '{"neg_half",    16'hC000, 4'b1000};
    vecs[5] = '{"pos_quarter", 16'h2000, 4'b1010};
    vecs[6] = '{"minus_one",   16'hFFFF, 4'b0100};

    // Reset state
    repeat (3) step();
    chk("reset_pdm_out", 32'(pdm_out), 32'd0);
    chk("reset_pdm_clk", 32'(pdm_clk), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    chk("reset_tready", 32'(s_tready), 32'd0);
    rst = 1'b0;
    step();
    chk("tready_after_reset", 32'(s_tready), 32'd1);

    // One slot per vector: sample buffered while idle, then enable starts a fresh slot
    for (int i = 0; i < 7; i++) begin
      step();
      enable = 1'b0;
      step();
      send(vecs[i].smp);
      enable = 1'b1;
      wait_ticks(4, bits);
      chk(vecs[i].nm, 32'(bits), 32'(vecs[i].bits));
      step();
      enable = 1'b0;
    end

    // Continuous stream of zeros with valid held high: no underrun, alternating bits
    step();
    s_tdata  = 16'h0000;
    s_tvalid = 1'b1;
    enable   = 1'b1;
    u0 = n_under;
    wait_ticks(12, bits);
    chk("stream_zero_bits", 32'(bits), 32'b1010);
    step();
    chk("stream_no_underrun", 32'(n_under - u0), 32'd0);
    s_tvalid = 1'b0;
    wait_ticks(8, bits);

    // Starved slots: one underrun per slot, bits follow a zero sample
    step();
    enable = 1'b0;
    step();
    u0 = n_under;
    enable = 1'b1;
    wait_ticks(8, bits);
    chk("starved_bits", 32'(bits), 32'b1010);
    step();
    chk("starved_underruns", 32'(n_under - u0), 32'd2);

    // Handshake on the exact load edge with an empty buffer takes the bypass path
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (!(since_ok && since == CD - 2 && m_bitcnt == 0 && sb_q.size() == 0) && t < 100);
    chk("bypass_align_timeout", 32'(t < 100), 32'd1);
    #1;
    u0 = n_under;
    s_tdata  = 16'h7FFF;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    wait_ticks(4, bits);
    chk("bypass_bits", 32'(bits), 32'b1110);
    step();
    chk("bypass_no_underrun", 32'(n_under - u0), 32'd0);

    // Disable mid-slot with a sample waiting; re-enable restarts the slot on that sample
    send(16'h4000);
    wait_ticks(1, bits);
    send(16'h7FFF);
    wait_ticks(1, bits);
    repeat (4) step();
    enable = 1'b0;
    step();
    chk("disable_pdm_clk", 32'(pdm_clk), 32'd0);
    chk("disable_pdm_out", 32'(pdm_out), 32'd0);
    chk("disable_tready_buf_kept", 32'(s_tready), 32'd0);
    repeat (4) step();
    u0 = n_under;
    enable = 1'b1;
    wait_ticks(4, bits);
    chk("reenable_bits", 32'(bits), 32'b1110);
    step();
    chk("reenable_no_underrun", 32'(n_under - u0), 32'd0);

    // Reset mid-stream discards the buffered sample
    send(16'h1234);
    rst = 1'b1;
    step();
    chk("tready_in_rst", 32'(s_tready), 32'd0);
    rst = 1'b0;
    step();
    chk("tready_after_rst", 32'(s_tready), 32'd1);
    wait_ticks(1, bits);
    chk("underrun_after_rst", 32'(underrun), 32'd1);

    step();
    enable = 1'b0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
